// File: rtl/uart_key_encode.sv
// uart_key_encode: turns debounced button presses, held-key auto-repeat and
// release events into single ASCII bytes for the UART TX FIFO write port.
// Pending flags remember events until their byte is issued; a repeat counter
// re-announces held buttons; a two-state FSM issues at most one byte every
// two cycles, highest priority first (release, Up, Down, Left, Right, Attack).
module uart_key_encode #(
  parameter int unsigned REPEAT_CYCLES = 6_500_000,
  parameter int unsigned CNT_W         = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnUp,
  input  logic       btnDown,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic       btnAttack,
  input  logic       full,
  output logic       wr_uart,
  output logic [7:0] w_data
);

  localparam int unsigned NBTN = 5;
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  // Button codes; bit index in the button vectors follows priority order.
  localparam logic [7:0] CODE_REL    = 8'h00;
  localparam logic [7:0] CODE_UP     = 8'h77;
  localparam logic [7:0] CODE_DOWN   = 8'h73;
  localparam logic [7:0] CODE_LEFT   = 8'h61;
  localparam logic [7:0] CODE_RIGHT  = 8'h64;
  localparam logic [7:0] CODE_ATTACK = 8'h20;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } stateT;

  stateT state;
  stateT stateNext;

  logic [NBTN-1:0]  btnRaw;
  logic [NBTN-1:0]  btnQ;
  logic [NBTN-1:0]  btnP;
  logic [NBTN-1:0]  rise;
  logic [NBTN-1:0]  fall;
  logic [NBTN-1:0]  pend;
  logic [NBTN-1:0]  pendSet;
  logic [NBTN-1:0]  pendClr;
  logic             pendRel;
  logic             relSet;
  logic             relClr;
  logic [CNT_W-1:0] rcnt;
  logic             rcntClr;
  logic             expire;
  logic             wrNext;
  logic [7:0]       dataNext;

  // Bit 0 = Up (highest button priority) .. bit 4 = Attack (lowest).
  assign btnRaw = {btnAttack, btnRight, btnLeft, btnDown, btnUp};

  // Input stage: sample buttons and keep the previous sample for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      btnQ <= '0;
      btnP <= '0;
    end else begin
      btnQ <= btnRaw;
      btnP <= btnQ;
    end
  end

  // Edge detection, repeat-counter clear and expiry, and flag set terms.
  always_comb begin
    rise    = btnQ & ~btnP;
    fall    = ~btnQ & btnP;
    rcntClr = (|rise) | (|fall) | (btnQ == '0);
    expire  = !rcntClr && (rcnt == RPT_LAST);
    relSet  = |fall;
    // After a release the peer clears everything, so re-announce what is still held.
    pendSet = rise | ({NBTN{relSet}} & btnQ) | ({NBTN{expire}} & btnQ);
  end

  // Repeat counter: runs while a stable non-empty set of buttons is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
    end else if (rcntClr || expire) begin
      rcnt <= '0;
    end else begin
      rcnt <= rcnt + CNT_W'(1);
    end
  end

  // Pending flags: a set in the same cycle as the issuing clear takes precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend    <= '0;
      pendRel <= 1'b0;
    end else begin
      pend    <= (pend & ~pendClr) | pendSet;
      pendRel <= (pendRel & ~relClr) | relSet;
    end
  end

  // FSM next state and output: pick the highest-priority pending event in IDLE.
  always_comb begin
    stateNext = state;
    wrNext    = 1'b0;
    dataNext  = w_data;
    pendClr   = '0;
    relClr    = 1'b0;
    case (state)
      IDLE: begin
        if ((pendRel || (|pend)) && !full) begin
          stateNext = SEND;
          wrNext    = 1'b1;
          if (pendRel) begin
            dataNext = CODE_REL;
            relClr   = 1'b1;
          end else if (pend[0]) begin
            dataNext   = CODE_UP;
            pendClr[0] = 1'b1;
          end else if (pend[1]) begin
            dataNext   = CODE_DOWN;
            pendClr[1] = 1'b1;
          end else if (pend[2]) begin
            dataNext   = CODE_LEFT;
            pendClr[2] = 1'b1;
          end else if (pend[3]) begin
            dataNext   = CODE_RIGHT;
            pendClr[3] = 1'b1;
          end else begin
            dataNext   = CODE_ATTACK;
            pendClr[4] = 1'b1;
          end
        end
      end
      SEND: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; the strobe is high for the SEND cycle only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      wr_uart <= 1'b0;
      w_data  <= 8'h00;
    end else begin
      state   <= stateNext;
      wr_uart <= wrNext;
      w_data  <= dataNext;
    end
  end

endmodule

// File: tb/tb_uart_key_encode.sv
// Testbench for uart_key_encode: directed vector table, hand-written
// multi-cycle sequences, and randomized stimulus checked every cycle
// against an event-level reference model.
module tb_uart_key_encode;

  localparam int unsigned RPT = 16;
  localparam int unsigned CW  = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] btn;   // bit0 Up, bit1 Down, bit2 Left, bit3 Right, bit4 Attack
  logic       full;
  logic       wr_uart;
  logic [7:0] w_data;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit checkEn = 1'b0;

  typedef struct {
    int         stamp;
    logic [7:0] data;
  } wrRecT;
  wrRecT wlog[$];

  typedef struct {
    logic [4:0] btn;
    logic       expWr;
    logic [7:0] expData;
  } vecT;
  vecT vt[19];

  // Reference model state, kept in event terms: held buttons, pending
  // announcements (index 0 = release, 1..5 = buttons by priority), the
  // length of the current steady hold, and whether a byte is on the bus.
  bit         mHeld[5];
  bit         mPrev[5];
  bit         mPend[6];
  int         mSteady;
  bit         mBusy;
  logic       mWr;
  logic [7:0] mData;
  logic [7:0] codes[6];

  always #5 clk = ~clk;

  uart_key_encode #(
    .REPEAT_CYCLES(RPT),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btnUp(btn[0]),
    .btnDown(btn[1]),
    .btnLeft(btn[2]),
    .btnRight(btn[3]),
    .btnAttack(btn[4]),
    .full(full),
    .wr_uart(wr_uart),
    .w_data(w_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic modelStep();
    bit rise[5];
    bit fallAny;
    bit changed;
    bit anyHeld;
    bit expire;
    int winner;
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        mHeld[i] = 1'b0;
        mPrev[i] = 1'b0;
      end
      for (int k = 0; k < 6; k++) mPend[k] = 1'b0;
      mSteady = 0;
      mBusy   = 1'b0;
      mWr     = 1'b0;
      mData   = 8'h00;
      return;
    end
    fallAny = 1'b0;
    changed = 1'b0;
    anyHeld = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rise[i] = mHeld[i] && !mPrev[i];
      if (!mHeld[i] && mPrev[i]) fallAny = 1'b1;
      if (mHeld[i] != mPrev[i]) changed = 1'b1;
      if (mHeld[i]) anyHeld = 1'b1;
    end
    if (changed || !anyHeld) mSteady = 0;
    else mSteady = mSteady + 1;
    expire = (mSteady > 0) && (mSteady % RPT == 0);
    winner = -1;
    if (!mBusy && !full) begin
      for (int k = 0; k < 6; k++) begin
        if (mPend[k] && winner < 0) winner = k;
      end
    end
    if (winner >= 0) mPend[winner] = 1'b0;
    if (fallAny) mPend[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (rise[i] || (mHeld[i] && (fallAny || expire))) mPend[i+1] = 1'b1;
    end
    mBusy = (winner >= 0);
    mWr   = mBusy;
    if (mBusy) mData = codes[winner];
    for (int i = 0; i < 5; i++) begin
      mPrev[i] = mHeld[i];
      mHeld[i] = btn[i];
    end
  endtask

  // Per-cycle monitor: step the model, log writes, compare outputs.
  initial begin
    forever begin
      @(posedge clk);
      modelStep();
      cyc++;
      #1;
      if (wr_uart === 1'b1) wlog.push_back('{cyc, w_data});
      if (checkEn) begin
        check("model_wr", 32'(wr_uart), 32'(mWr));
        check("model_data", 32'(w_data), 32'(mData));
      end
    end
  end

  initial begin
    int pressCyc;
    int expStamp[5];
    logic [7:0] expByte[5];
    logic [7:0] fullSeq[3];

    codes[0] = 8'h00; codes[1] = 8'h77; codes[2] = 8'h73;
    codes[3] = 8'h61; codes[4] = 8'h64; codes[5] = 8'h20;

    // Directed table: inputs applied for one cycle, outputs seen after that edge.
    vt[0]  = '{5'b00000, 1'b0, 8'h00};
    vt[1]  = '{5'b00001, 1'b0, 8'h00};
    vt[2]  = '{5'b00001, 1'b0, 8'h00};
    vt[3]  = '{5'b00001, 1'b1, 8'h77};
    vt[4]  = '{5'b00001, 1'b0, 8'h00};
    vt[5]  = '{5'b11111, 1'b0, 8'h00};
    vt[6]  = '{5'b11111, 1'b0, 8'h00};
    vt[7]  = '{5'b11111, 1'b1, 8'h73};
    vt[8]  = '{5'b11111, 1'b0, 8'h00};
    vt[9]  = '{5'b11111, 1'b1, 8'h61};
    vt[10] = '{5'b11111, 1'b0, 8'h00};
    vt[11] = '{5'b11111, 1'b1, 8'h64};
    vt[12] = '{5'b11111, 1'b0, 8'h00};
    vt[13] = '{5'b11111, 1'b1, 8'h20};
    vt[14] = '{5'b11111, 1'b0, 8'h00};
    vt[15] = '{5'b00000, 1'b0, 8'h00};
    vt[16] = '{5'b00000, 1'b0, 8'h00};
    vt[17] = '{5'b00000, 1'b1, 8'h00};
    vt[18] = '{5'b00000, 1'b0, 8'h00};

    rst  = 1'b1;
    btn  = 5'b00000;
    full = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_wr", 32'(wr_uart), 32'd0);
    check("reset_data", 32'(w_data), 32'h00);
    checkEn = 1'b1;
    rst = 1'b0;

    // Quiet inputs produce no traffic.
    wlog.delete();
    repeat (100) @(negedge clk);
    check("idle_writes", 32'(wlog.size()), 32'd0);

    // Single press latency, simultaneous press ordering, release byte.
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      btn = vt[i].btn;
      @(posedge clk);
      #2;
      check("vec_wr", 32'(wr_uart), 32'(vt[i].expWr));
      if (vt[i].expWr) check("vec_data", 32'(w_data), 32'(vt[i].expData));
    end

    // Held Attack: press byte, three repeats RPT apart, then release.
    @(negedge clk);
    wlog.delete();
    pressCyc = cyc + 1;
    btn = 5'b10000;
    repeat (60) @(negedge clk);
    btn = 5'b00000;
    repeat (10) @(negedge clk);
    expStamp[0] = pressCyc + 2;  expByte[0] = 8'h20;
    expStamp[1] = pressCyc + 18; expByte[1] = 8'h20;
    expStamp[2] = pressCyc + 34; expByte[2] = 8'h20;
    expStamp[3] = pressCyc + 50; expByte[3] = 8'h20;
    expStamp[4] = pressCyc + 62; expByte[4] = 8'h00;
    check("hold_count", 32'(wlog.size()), 32'd5);
    if (wlog.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("hold_stamp", 32'(wlog[i].stamp), 32'(expStamp[i]));
        check("hold_byte", 32'(wlog[i].data), 32'(expByte[i]));
      end
    end

    // FIFO full: events accumulate; the Left press is kept until issued.
    @(negedge clk);
    wlog.delete();
    full = 1'b1;
    btn = 5'b00100;
    repeat (2) @(negedge clk);
    btn = 5'b00000;
    repeat (2) @(negedge clk);
    btn = 5'b01000;
    repeat (4) @(negedge clk);
    check("full_nowrite", 32'(wlog.size()), 32'd0);
    full = 1'b0;
    repeat (10) @(negedge clk);
    fullSeq[0] = 8'h00; fullSeq[1] = 8'h61; fullSeq[2] = 8'h64;
    check("full_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() >= 3) begin
      for (int i = 0; i < 3; i++) check("full_byte", 32'(wlog[i].data), 32'(fullSeq[i]));
    end
    btn = 5'b00000;
    repeat (6) @(negedge clk);

    // Reset during SEND discards the remaining pending events.
    wlog.delete();
    btn = 5'b01111;
    repeat (3) @(negedge clk);
    check("send_before_rst", 32'(wr_uart), 32'd1);
    rst = 1'b1;
    btn = 5'b00000;
    @(negedge clk);
    check("rst_drops_wr", 32'(wr_uart), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("post_rst_writes", 32'(wlog.size()), 32'd1);
    if (wlog.size() >= 1) check("post_rst_byte", 32'(wlog[0].data), 32'h77);

    // Randomized traffic with long holds, FIFO back-pressure and rare resets.
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) btn = 5'($urandom_range(0, 31));
      full = ($urandom_range(0, 3) == 0);
      rst  = ($urandom_range(0, 499) == 0);
    end
    @(negedge clk);
    rst  = 1'b0;
    full = 1'b0;
    btn  = 5'b00000;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
